wb_burst_master: RTL and testbench
==================================

WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameters SHALL be: DW, 32, data width (32 or 64); AW, 32, address width; MAX_BURST, 16, maximum beats per transfer (power of 2); TIMEOUT, 255, cycles without termination before abort; RETRY_MAX, 3, retries per beat on rty.
REQ-002 Ports SHALL be: wb_clk  in  1  clock; wb_rst_n  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
REQ-003 Bus ports SHALL be: wb_adr_o out AW; wb_dat_o out DW; wb_sel_o out DW/8; wb_we_o, wb_cyc_o, wb_stb_o out 1; wb_cti_o out 3; wb_bte_o out 2; wb_dat_i in DW; wb_ack_i, wb_err_i, wb_rty_i in 1.
REQ-004 User ports SHALL be: start in 1 (command pulse); address in AW; selection in DW/8; write in 1; burst_len in clog2(MAX_BURST)+1 (beats, 1..MAX_BURST); data_wr in DW; wr_next out 1 (write beat consumed, present next data); data_rd out DW; rd_valid out 1; active out 1; done out 1 (one-cycle pulse); status out 2 (00 OK, 01 ERR, 10 RTY_FAIL, 11 TIMEOUT).

Function
REQ-005 States SHALL be IDLE, BUS, BACKOFF, FINISH.
REQ-006 In IDLE, start=1 SHALL latch address, selection, write, burst_len and enter BUS; cyc/stb assert the following cycle; active asserts the same following cycle.
REQ-007 start while not IDLE SHALL be ignored; burst_len 0 or >MAX_BURST SHALL be clamped to 1 and MAX_BURST respectively.
REQ-008 In BUS, cyc and stb SHALL stay high until the last beat acks, err, retry exhaustion or timeout; wb_we_o, wb_sel_o constant for the transfer.
REQ-009 wb_cti_o SHALL be 000 when burst_len=1, 010 on non-final beats, 111 on the final beat of a burst; wb_bte_o SHALL be 00.
REQ-010 Each ack SHALL advance wb_adr_o by DW/8 modulo 2^AW (wrap permitted, no boundary check) and decrement the beat counter.
REQ-011 Writes: wb_dat_o SHALL equal data_wr sampled combinationally; wr_next SHALL pulse in the cycle of each write ack.
REQ-012 Reads: data_rd SHALL register wb_dat_i on ack; rd_valid SHALL pulse one cycle after each read ack; data_rd holds until the next ack.
REQ-013 ack on the final beat SHALL go to FINISH with status 00.
REQ-014 err SHALL drop cyc/stb next cycle, go to FINISH with status 01; err and ack in the same cycle SHALL be treated as err.
REQ-015 rty (without err) SHALL drop cyc/stb for exactly one cycle (BACKOFF) then re-issue the same beat, same address; retry counter resets on each ack; the (RETRY_MAX+1)th rty on one beat SHALL go to FINISH with status 10; rty with ack SHALL be treated as ack.
REQ-016 The timeout counter SHALL reset on entering BUS and on each ack/rty; reaching TIMEOUT cycles SHALL go to FINISH with status 11.
REQ-017 FINISH SHALL last one cycle: done=1, cyc/stb=0, active=0 next cycle, return to IDLE; status holds until the next start.

Reset
REQ-018 wb_rst_n low SHALL force IDLE immediately: all bus outputs 0, cti 000, bte 00, data_rd 0, rd_valid/wr_next/done/active 0, status 00, counters 0.
REQ-019 Reset mid-transfer SHALL abort with no done pulse; first start after release begins a fresh transfer.

Structure
REQ-020 Shared package wb_master_pkg SHALL hold state encoding, CTI/BTE constants and status codes.
REQ-021 One sub-module wb_beat_counter (beat/retry/timeout counting) is natural; FSM and datapath remain in wb_burst_master.

Verification
REQ-022 Single read: start, address 0x100, burst_len 1, slave acks after 2 waits, data 0xDEADBEEF -> cti 000, rd_valid once with data_rd 0xDEADBEEF, done, status 00.
REQ-023 4-beat write at 0x200, zero-wait slave -> adr 0x200,0x204,0x208,0x20C; cti 010,010,010,111; 4 wr_next pulses; done 1 cycle after last ack.
REQ-024 Read burst 4, slave asserts err on beat 2 -> cyc low next cycle, 2 rd_valid total (none for err), status 01.
REQ-025 Single write, slave rty 4 times with RETRY_MAX=3 -> 3 one-cycle stb gaps, status 10; with rty twice then ack -> status 00.
REQ-026 Silent slave, TIMEOUT=255 -> done 255 cycles after stb rise, status 11; wb_rst_n pulsed mid-burst -> outputs 0 immediately, no done.
REQ-027 Address wrap AW=32 at 0xFFFFFFFC burst 2 -> second beat adr 0x00000000.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared definitions for the Wishbone burst master: FSM state encoding,
// cycle-type/burst-type constants and transfer status codes.
package wb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_FINISH  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK       = 2'b00,
    STAT_ERR      = 2'b01,
    STAT_RTY_FAIL = 2'b10,
    STAT_TIMEOUT  = 2'b11
  } status_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_beat_counter.sv
// Beat, retry and timeout counters for one burst. The FSM qualifies the
// strobes, so every input here is already a decided event.
module wb_beat_counter
  import wb_master_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 255,
  parameter int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [LW-1:0] len,
  input  logic          beat_ack,
  input  logic          beat_rty,
  input  logic          in_bus,
  output logic          last_beat,
  output logic          rty_exhausted,
  output logic          timed_out
);

  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(RETRY_MAX);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [LW-1:0] beat_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] tmo_q;

  assign last_beat     = (beat_q == LW'(1));
  assign rty_exhausted = (retry_q == RTY_LAST);
  assign timed_out     = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
    end else begin
      if (load)          beat_q <= len;
      else if (beat_ack) beat_q <= beat_q - LW'(1);

      if (load || beat_ack)                 retry_q <= '0;
      else if (beat_rty && !rty_exhausted)  retry_q <= retry_q + RW'(1);

      // Restarts on every BUS entry because it is held at zero outside BUS.
      if (!in_bus || beat_ack || beat_rty) tmo_q <= '0;
      else if (!timed_out)                 tmo_q <= tmo_q + TW'(1);
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B4 incrementing-burst master: one command per start pulse,
// with retry backoff, error abort and a no-response timeout.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 3,
  localparam int LW       = $clog2(MAX_BURST) + 1,
  localparam int SW       = DW / 8
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic          start,
  input  logic [AW-1:0] address,
  input  logic [SW-1:0] selection,
  input  logic          write,
  input  logic [LW-1:0] burst_len,
  input  logic [DW-1:0] data_wr,
  output logic          wr_next,
  output logic [DW-1:0] data_rd,
  output logic          rd_valid,
  output logic          active,
  output logic          done,
  output logic [1:0]    status,
  output state_t        state_dbg
);

  state_t        state_q, state_d;
  status_t       status_q, status_d;
  logic          load;
  logic [AW-1:0] adr_q;
  logic [SW-1:0] sel_q;
  logic          we_q;
  logic          single_q;
  logic [DW-1:0] data_rd_q;
  logic          rd_valid_q;
  logic [LW-1:0] len_clamped;
  logic          in_bus, beat_ack, beat_rty, beat_err;
  logic          last_beat, rty_exhausted, timed_out;

  // Handshake: a beat terminates on any cycle where stb is high and the slave
  // returns ack, err or rty. err dominates ack, ack dominates rty; with no
  // termination the master holds address/data/select stable and keeps waiting.
  assign in_bus   = (state_q == ST_BUS);
  assign beat_err = in_bus && wb_err_i;
  assign beat_ack = in_bus && wb_ack_i && !wb_err_i;
  assign beat_rty = in_bus && wb_rty_i && !wb_ack_i && !wb_err_i;

  always_comb begin
    len_clamped = burst_len;
    if (burst_len == '0)                  len_clamped = LW'(1);
    else if (burst_len > LW'(MAX_BURST))  len_clamped = LW'(MAX_BURST);
  end

  wb_beat_counter #(
    .MAX_BURST(MAX_BURST),
    .RETRY_MAX(RETRY_MAX),
    .TIMEOUT  (TIMEOUT),
    .LW       (LW)
  ) u_cnt (
    .clk          (wb_clk),
    .rst_n        (wb_rst_n),
    .load         (load),
    .len          (len_clamped),
    .beat_ack     (beat_ack),
    .beat_rty     (beat_rty),
    .in_bus       (in_bus),
    .last_beat    (last_beat),
    .rty_exhausted(rty_exhausted),
    .timed_out    (timed_out)
  );

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          status_d = STAT_OK;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        if (beat_err) begin
          status_d = STAT_ERR;
          state_d  = ST_FINISH;
        end else if (beat_ack) begin
          if (last_beat) state_d = ST_FINISH;
        end else if (beat_rty) begin
          if (rty_exhausted) begin
            status_d = STAT_RTY_FAIL;
            state_d  = ST_FINISH;
          end else begin
            state_d = ST_BACKOFF;
          end
        end else if (timed_out) begin
          status_d = STAT_TIMEOUT;
          state_d  = ST_FINISH;
        end
      end
      ST_BACKOFF: state_d = ST_BUS;
      ST_FINISH:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      status_q   <= STAT_OK;
      adr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      single_q   <= 1'b0;
      data_rd_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      rd_valid_q <= beat_ack && !we_q;
      if (load) begin
        adr_q    <= address;
        sel_q    <= selection;
        we_q     <= write;
        single_q <= (len_clamped == LW'(1));
      end else if (beat_ack) begin
        adr_q <= adr_q + AW'(SW);
      end
      if (beat_ack && !we_q) data_rd_q <= wb_dat_i;
    end
  end

  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = in_bus;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_dat_o  = (in_bus && we_q) ? data_wr : '0;
  assign wb_bte_o  = BTE_LINEAR;
  assign wb_cti_o  = (!in_bus || single_q) ? CTI_CLASSIC :
                     (last_beat ? CTI_EOB : CTI_INCR);

  assign wr_next   = beat_ack && we_q;
  assign data_rd   = data_rd_q;
  assign rd_valid  = rd_valid_q;
  assign active    = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign status    = status_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: a scripted slave plus a
// transaction-level reference model of the expected beats and outcome.
module tb_wb_burst_master;
  import wb_master_pkg::*;

  localparam int DW = 32, AW = 32, MAX_BURST = 16, TIMEOUT = 255, RETRY_MAX = 3;
  localparam int LW = $clog2(MAX_BURST) + 1, SW = DW / 8;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_SIL = 3, K_ERR_ACK = 4, K_RTY_ACK = 5;
  localparam int NSCR = 128;

  logic          wb_clk, wb_rst_n;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i, data_wr, data_rd;
  logic [SW-1:0] wb_sel_o, selection;
  logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o, status;
  logic          start, write, wr_next, rd_valid, active, done;
  logic [AW-1:0] address;
  logic [LW-1:0] burst_len;
  state_t        state_dbg;

  wb_burst_master #(
    .DW(DW), .AW(AW), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .start(start), .address(address), .selection(selection), .write(write),
    .burst_len(burst_len), .data_wr(data_wr), .wr_next(wr_next), .data_rd(data_rd),
    .rd_valid(rd_valid), .active(active), .done(done), .status(status), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_cmp = 0, n_fail = 0;

  // ---------------- slave script ----------------
  int            resp_kind [NSCR];
  int            resp_wait [NSCR];
  logic [DW-1:0] resp_data [NSCR];

  // ---------------- reference model results ----------------
  logic [AW-1:0] exp_adr_q[$];
  logic [2:0]    exp_cti_q[$];
  logic [DW-1:0] exp_rd_q[$];
  int            exp_wr, exp_lat, exp_gaps;
  logic [1:0]    exp_status;

  // ---------------- observations ----------------
  logic [AW-1:0] obs_adr_q[$];
  logic [2:0]    obs_cti_q[$];
  logic [DW-1:0] obs_rd_q[$];
  int            obs_wr, obs_lat, obs_gaps, obs_done, obs_viol;
  logic [1:0]    obs_status, obs_status_hold;
  logic          obs_active_after, obs_cyc_done, obs_finished;

  // Walks the script one attempt at a time, applying the transfer rules.
  function automatic void model(input logic [AW-1:0] addr, input int len_in, input logic we);
    int len, b, tries, i, k;
    exp_adr_q.delete(); exp_cti_q.delete(); exp_rd_q.delete();
    exp_wr = 0; exp_lat = 0; exp_gaps = 0; exp_status = 2'b00;
    len = (len_in == 0) ? 1 : ((len_in > MAX_BURST) ? MAX_BURST : len_in);
    b = 0; tries = 0; i = 0;
    while (i < NSCR) begin
      exp_adr_q.push_back(addr + AW'(b * SW));
      exp_cti_q.push_back(len == 1 ? 3'b000 : ((b == len - 1) ? 3'b111 : 3'b010));
      k = resp_kind[i];
      if (k == K_SIL) begin exp_lat += TIMEOUT; exp_status = 2'b11; break; end
      exp_lat += resp_wait[i] + 1;
      if (k == K_ERR || k == K_ERR_ACK) begin exp_status = 2'b01; break; end
      if (k == K_RTY) begin
        if (tries == RETRY_MAX) begin exp_status = 2'b10; break; end
        tries++; exp_gaps++; exp_lat++;
      end else begin
        if (we) exp_wr++; else exp_rd_q.push_back(resp_data[i]);
        b++; tries = 0;
        if (b == len) begin exp_status = 2'b00; break; end
      end
      i++;
    end
  endfunction

  task automatic fill_script(input int kind, input int waits);
    for (int i = 0; i < NSCR; i++) begin
      resp_kind[i] = kind; resp_wait[i] = waits; resp_data[i] = $urandom;
    end
  endtask

  task automatic random_script();
    int r;
    for (int i = 0; i < NSCR; i++) begin
      r = $urandom_range(0, 99);
      resp_kind[i] = (r < 80) ? K_ACK : (r < 90) ? K_RTY : (r < 93) ? K_ERR :
                     (r < 95) ? K_ERR_ACK : (r < 98) ? K_RTY_ACK : K_SIL;
      resp_wait[i] = $urandom_range(0, 3);
      resp_data[i] = $urandom;
    end
  endtask

  // ---------------- driver + slave + monitor ----------------
  task automatic run_xfer(input logic [AW-1:0] addr, input logic [SW-1:0] sel,
                          input logic we, input int len_in, input bit noisy);
    int t0, dcyc, idx, wc, last_rd_ack, k;
    bit in_att, renew;
    logic [AW-1:0] att_adr;
    obs_adr_q.delete(); obs_cti_q.delete(); obs_rd_q.delete();
    obs_wr = 0; obs_lat = -1; obs_gaps = 0; obs_done = 0; obs_viol = 0;
    obs_status = 'x; obs_status_hold = 'x; obs_active_after = 1'bx; obs_cyc_done = 1'bx;
    obs_finished = 1'b0;
    @(negedge wb_clk);
    address = addr; selection = sel; write = we; burst_len = LW'(len_in);
    data_wr = $urandom; start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0;
    t0 = -1; dcyc = -1; idx = 0; wc = 0; last_rd_ack = -10; in_att = 0; renew = 0; att_adr = '0;
    for (int t = 0; t < 3000; t++) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (renew) begin data_wr = $urandom; renew = 0; end
      if (noisy && active && !done) begin
        start = 1'($urandom_range(0, 1)); address = $urandom; write = ~we; burst_len = LW'($urandom);
      end else start = 1'b0;
      if (done) begin
        obs_done++;
        if (dcyc < 0) begin dcyc = t; obs_lat = t - t0; obs_status = status; obs_cyc_done = wb_cyc_o; end
      end
      if (rd_valid) begin
        obs_rd_q.push_back(data_rd);
        if (last_rd_ack != t - 1) obs_viol++;
      end
      if (active && !wb_cyc_o && !done) obs_gaps++;
      if (wb_cyc_o && wb_stb_o) begin
        if (t0 < 0) t0 = t;
        if (!in_att) begin
          obs_adr_q.push_back(wb_adr_o); obs_cti_q.push_back(wb_cti_o);
          att_adr = wb_adr_o; in_att = 1; wc = 0;
        end
        if (wb_adr_o !== att_adr || wb_sel_o !== sel || wb_we_o !== we || wb_bte_o !== 2'b00)
          obs_viol++;
        k = (idx < NSCR) ? resp_kind[idx] : K_SIL;
        if (k != K_SIL && wc == resp_wait[idx]) begin
          wb_ack_i = (k == K_ACK || k == K_ERR_ACK || k == K_RTY_ACK);
          wb_err_i = (k == K_ERR || k == K_ERR_ACK);
          wb_rty_i = (k == K_RTY || k == K_RTY_ACK);
          wb_dat_i = resp_data[idx];
          if (!we && (k == K_ACK || k == K_RTY_ACK)) last_rd_ack = t;
          in_att = 0; idx++;
        end else wc++;
      end else if (wb_cyc_o !== wb_stb_o) obs_viol++;
      #1;
      if (wr_next) begin obs_wr++; renew = 1; end
      if (wb_stb_o && we && wb_dat_o !== data_wr) obs_viol++;
      if (dcyc >= 0 && t == dcyc + 1) obs_active_after = active;
      if (dcyc >= 0 && t == dcyc + 4) begin obs_status_hold = status; obs_finished = 1; break; end
      @(negedge wb_clk);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; start = 1'b0;
    if (!obs_finished) begin
      n_cmp++; n_fail++;
      $display("FAIL xfer_bound no done within cycle budget got=none exp=done");
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got cyc=%b stb=%b adr=%h dat=%h cti=%b exp=all zero",
               wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_cti_o);
    end
    n_cmp++;
    if ({data_rd, rd_valid, wr_next, done, active, status} !== '0 || state_dbg !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_user got rd=%h rv=%b wn=%b done=%b act=%b st=%b exp=all zero",
               data_rd, rd_valid, wr_next, done, active, status);
    end
  endtask

  task automatic test_single_read();
    fill_script(K_ACK, 2);
    resp_data[0] = 32'hDEADBEEF;
    model(32'h100, 1, 1'b0);
    run_xfer(32'h100, 4'hF, 1'b0, 1, 0);
    n_cmp++;
    if (obs_cti_q.size() != 1 || obs_cti_q[0] !== 3'b000) begin
      n_fail++; $display("FAIL single_read_cti got=%b n=%0d exp=000 n=1", obs_cti_q[0], obs_cti_q.size());
    end
    n_cmp++;
    if (obs_rd_q.size() != 1 || obs_rd_q[0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_read_data got=%h n=%0d exp=deadbeef n=1", obs_rd_q[0], obs_rd_q.size());
    end
    n_cmp++;
    if (obs_status !== 2'b00 || obs_done != 1 || obs_lat != exp_lat) begin
      n_fail++; $display("FAIL single_read_done got st=%b done=%0d lat=%0d exp st=00 done=1 lat=%0d",
                         obs_status, obs_done, obs_lat, exp_lat);
    end
  endtask

  task automatic test_burst_write();
    fill_script(K_ACK, 0);
    model(32'h200, 4, 1'b1);
    run_xfer(32'h200, 4'hF, 1'b1, 4, 0);
    n_cmp++;
    if (obs_adr_q.size() != 4) begin
      n_fail++; $display("FAIL burst_write_beats got=%0d exp=4", obs_adr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_adr_q[i] !== exp_adr_q[i] || obs_cti_q[i] !== exp_cti_q[i]) begin
        n_fail++; $display("FAIL burst_write_beat%0d got adr=%h cti=%b exp adr=%h cti=%b",
                           i, obs_adr_q[i], obs_cti_q[i], exp_adr_q[i], exp_cti_q[i]);
      end
    end
    n_cmp++;
    if (obs_wr != 4 || obs_lat != 4 || obs_viol != 0) begin
      n_fail++; $display("FAIL burst_write_wrnext got wr=%0d lat=%0d viol=%0d exp wr=4 lat=4 viol=0",
                         obs_wr, obs_lat, obs_viol);
    end
  endtask

  task automatic test_err();
    fill_script(K_ACK, 0);
    resp_kind[2] = K_ERR; resp_wait[1] = 1;
    model(32'h300, 4, 1'b0);
    run_xfer(32'h300, 4'h3, 1'b0, 4, 0);
    n_cmp++;
    if (obs_status !== 2'b01 || obs_rd_q.size() != 2 || obs_cyc_done !== 1'b0 || obs_lat != exp_lat) begin
      n_fail++; $display("FAIL err_abort got st=%b rv=%0d cyc=%b lat=%0d exp st=01 rv=2 cyc=0 lat=%0d",
                         obs_status, obs_rd_q.size(), obs_cyc_done, obs_lat, exp_lat);
    end
    fill_script(K_ACK, 0);
    resp_kind[1] = K_ERR_ACK;
    model(32'h400, 4, 1'b0);
    run_xfer(32'h400, 4'hF, 1'b0, 4, 0);
    n_cmp++;
    if (obs_status !== 2'b01 || obs_rd_q.size() != 1 || obs_rd_q[0] !== exp_rd_q[0]) begin
      n_fail++; $display("FAIL err_with_ack got st=%b rv=%0d exp st=01 rv=1", obs_status, obs_rd_q.size());
    end
  endtask

  task automatic test_retry();
    fill_script(K_RTY, 0);
    model(32'h500, 1, 1'b1);
    run_xfer(32'h500, 4'hF, 1'b1, 1, 0);
    n_cmp++;
    if (obs_status !== 2'b10 || obs_gaps != 3 || obs_wr != 0 || obs_lat != exp_lat) begin
      n_fail++; $display("FAIL rty_exhaust got st=%b gaps=%0d wr=%0d lat=%0d exp st=10 gaps=3 wr=0 lat=%0d",
                         obs_status, obs_gaps, obs_wr, obs_lat, exp_lat);
    end
    n_cmp++;
    if (obs_adr_q.size() != 4 || obs_adr_q[3] !== 32'h500) begin
      n_fail++; $display("FAIL rty_same_adr got n=%0d adr=%h exp n=4 adr=00000500", obs_adr_q.size(), obs_adr_q[3]);
    end
    fill_script(K_ACK, 1);
    resp_kind[0] = K_RTY; resp_kind[1] = K_RTY;
    model(32'h600, 1, 1'b1);
    run_xfer(32'h600, 4'hF, 1'b1, 1, 0);
    n_cmp++;
    if (obs_status !== 2'b00 || obs_gaps != 2 || obs_wr != 1 || obs_lat != exp_lat) begin
      n_fail++; $display("FAIL rty_recover got st=%b gaps=%0d wr=%0d lat=%0d exp st=00 gaps=2 wr=1 lat=%0d",
                         obs_status, obs_gaps, obs_wr, obs_lat, exp_lat);
    end
    fill_script(K_ACK, 0);
    resp_kind[0] = K_RTY_ACK;
    model(32'h700, 2, 1'b0);
    run_xfer(32'h700, 4'hF, 1'b0, 2, 0);
    n_cmp++;
    if (obs_status !== 2'b00 || obs_gaps != 0 || obs_rd_q.size() != 2 || obs_lat != exp_lat) begin
      n_fail++; $display("FAIL rty_with_ack got st=%b gaps=%0d rv=%0d lat=%0d exp st=00 gaps=0 rv=2 lat=%0d",
                         obs_status, obs_gaps, obs_rd_q.size(), obs_lat, exp_lat);
    end
  endtask

  task automatic test_timeout();
    fill_script(K_SIL, 0);
    model(32'h800, 1, 1'b0);
    run_xfer(32'h800, 4'hF, 1'b0, 1, 0);
    n_cmp++;
    if (obs_status !== 2'b11 || obs_lat != 255 || obs_status_hold !== 2'b11) begin
      n_fail++; $display("FAIL timeout got st=%b lat=%0d hold=%b exp st=11 lat=255 hold=11",
                         obs_status, obs_lat, obs_status_hold);
    end
  endtask

  task automatic test_wrap();
    fill_script(K_ACK, 0);
    model(32'hFFFF_FFFC, 2, 1'b0);
    run_xfer(32'hFFFF_FFFC, 4'hF, 1'b0, 2, 0);
    n_cmp++;
    if (obs_adr_q.size() != 2 || obs_adr_q[1] !== 32'h0000_0000 || obs_cti_q[1] !== 3'b111) begin
      n_fail++; $display("FAIL wrap got n=%0d adr=%h cti=%b exp n=2 adr=00000000 cti=111",
                         obs_adr_q.size(), obs_adr_q[1], obs_cti_q[1]);
    end
  endtask

  task automatic test_clamp();
    fill_script(K_ACK, 0);
    model(32'h900, 0, 1'b1);
    run_xfer(32'h900, 4'h1, 1'b1, 0, 0);
    n_cmp++;
    if (obs_adr_q.size() != 1 || obs_cti_q[0] !== 3'b000 || obs_wr != 1) begin
      n_fail++; $display("FAIL clamp_zero got n=%0d cti=%b wr=%0d exp n=1 cti=000 wr=1",
                         obs_adr_q.size(), obs_cti_q[0], obs_wr);
    end
    model(32'hA00, 20, 1'b0);
    run_xfer(32'hA00, 4'hF, 1'b0, 20, 0);
    n_cmp++;
    if (obs_adr_q.size() != MAX_BURST || obs_rd_q.size() != MAX_BURST || obs_cti_q[MAX_BURST-1] !== 3'b111) begin
      n_fail++; $display("FAIL clamp_max got n=%0d rv=%0d exp n=%0d rv=%0d",
                         obs_adr_q.size(), obs_rd_q.size(), MAX_BURST, MAX_BURST);
    end
  endtask

  task automatic test_random(input int iters, input bit noisy);
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic          we;
    int            len;
    for (int it = 0; it < iters; it++) begin
      random_script();
      a   = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFC0 | AW'($urandom & 32'h3C)) : AW'($urandom & ~32'h3);
      s   = SW'($urandom);
      we  = 1'($urandom);
      len = $urandom_range(1, MAX_BURST);
      model(a, len, we);
      run_xfer(a, s, we, len, noisy);
      n_cmp++;
      if (obs_adr_q.size() != exp_adr_q.size()) begin
        n_fail++; $display("FAIL rand%0d_attempts got=%0d exp=%0d", it, obs_adr_q.size(), exp_adr_q.size());
      end
      for (int i = 0; i < exp_adr_q.size(); i++) begin
        n_cmp++;
        if (obs_adr_q[i] !== exp_adr_q[i] || obs_cti_q[i] !== exp_cti_q[i]) begin
          n_fail++; $display("FAIL rand%0d_beat%0d got adr=%h cti=%b exp adr=%h cti=%b",
                             it, i, obs_adr_q[i], obs_cti_q[i], exp_adr_q[i], exp_cti_q[i]);
        end
      end
      n_cmp++;
      if (obs_rd_q.size() != exp_rd_q.size()) begin
        n_fail++; $display("FAIL rand%0d_rdcount got=%0d exp=%0d", it, obs_rd_q.size(), exp_rd_q.size());
      end
      for (int i = 0; i < exp_rd_q.size(); i++) begin
        n_cmp++;
        if (obs_rd_q[i] !== exp_rd_q[i]) begin
          n_fail++; $display("FAIL rand%0d_rd%0d got=%h exp=%h", it, i, obs_rd_q[i], exp_rd_q[i]);
        end
      end
      n_cmp++;
      if (obs_status !== exp_status || obs_status_hold !== exp_status) begin
        n_fail++; $display("FAIL rand%0d_status got=%b hold=%b exp=%b", it, obs_status, obs_status_hold, exp_status);
      end
      n_cmp++;
      if (obs_wr != exp_wr || obs_gaps != exp_gaps || obs_lat != exp_lat) begin
        n_fail++; $display("FAIL rand%0d_timing got wr=%0d gaps=%0d lat=%0d exp wr=%0d gaps=%0d lat=%0d",
                           it, obs_wr, obs_gaps, obs_lat, exp_wr, exp_gaps, exp_lat);
      end
      n_cmp++;
      if (obs_done != 1 || obs_viol != 0 || obs_active_after !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_protocol got done=%0d viol=%0d act=%b exp done=1 viol=0 act=0",
                           it, obs_done, obs_viol, obs_active_after);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge wb_clk);
    address = 32'hB00; selection = 4'hF; write = 1'b0; burst_len = LW'(8); start = 1'b1;
    @(negedge wb_clk);
    start = 1'b0;
    repeat (10) @(negedge wb_clk);
    n_cmp++;
    if (wb_cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre got cyc=%b exp=1", wb_cyc_o);
    end
    #2 wb_rst_n = 1'b0;
    #1;
    test_reset();
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge wb_clk);
      if (done || wb_cyc_o || active) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_mid_quiet got=%0d busy cycles exp=0", bad);
    end
    fill_script(K_ACK, 1);
    model(32'hC00, 3, 1'b0);
    run_xfer(32'hC00, 4'hF, 1'b0, 3, 0);
    n_cmp++;
    if (obs_status !== 2'b00 || obs_rd_q.size() != 3 || obs_adr_q[0] !== 32'hC00 || obs_lat != exp_lat) begin
      n_fail++; $display("FAIL reset_mid_fresh got st=%b rv=%0d adr=%h lat=%0d exp st=00 rv=3 adr=00000c00 lat=%0d",
                         obs_status, obs_rd_q.size(), obs_adr_q[0], obs_lat, exp_lat);
    end
  endtask

  initial begin
    wb_rst_n = 1'b0;
    start = 1'b0; address = '0; selection = '0; write = 1'b0; burst_len = '0; data_wr = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    repeat (3) @(negedge wb_clk);
    test_reset();
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    test_single_read();
    test_burst_write();
    test_err();
    test_retry();
    test_timeout();
    test_wrap();
    test_clamp();
    test_random(25, 0);
    test_random(8, 1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
